rr_grant_arbiter: RTL and testbench

//   Round-robin request/grant arbiter. It is the DUT that sits directly downstream of the

---
 rtl/rr_grant_arbiter.sv | 100 ++++++++++
 tb/tb_rr_grant_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// Round-robin request/grant arbiter with registered one-hot grant and
// optional hold-time pre-emption of a persistent owner.
module rr_grant_arbiter #(
    parameter int unsigned N        = 2,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         request,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 grant_valid
);

    localparam int unsigned IDW     = $clog2(N);
    localparam int unsigned HW_RAW  = $clog2(MAX_HOLD + 1);
    localparam int unsigned HW      = (HW_RAW < 1) ? 1 : HW_RAW;
    localparam logic [HW-1:0] HOLD_MAX = (MAX_HOLD == 0) ? {HW{1'b1}} : HW'(MAX_HOLD);
    localparam logic [N-1:0]  ONE      = N'(1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [HW-1:0]    hold_cnt;
    logic [IDW-1:0]   last;

    logic             idle_found;
    logic [IDW-1:0]   idle_pick;
    logic             pre_found;
    logic [IDW-1:0]   pre_pick;

    // Index k positions after base, wrapping modulo N.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        return IDW'(s % N);
    endfunction

    // Scan descending so the nearest requester after the base wins.
    always_comb begin
        idle_found = 1'b0;
        idle_pick  = '0;
        pre_found  = 1'b0;
        pre_pick   = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            if (request[rr_idx(last, k)]) begin
                idle_found = 1'b1;
                idle_pick  = rr_idx(last, k);
            end
        end
        for (int unsigned k = N - 1; k >= 1; k--) begin
            if (request[rr_idx(grant_id, k)]) begin
                pre_found = 1'b1;
                pre_pick  = rr_idx(grant_id, k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            last        <= IDW'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (idle_found) begin
                        grant       <= ONE << idle_pick;
                        grant_id    <= idle_pick;
                        grant_valid <= 1'b1;
                        hold_cnt    <= HW'(1);
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (!request[grant_id]) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        last        <= grant_id;
                        hold_cnt    <= '0;
                        state       <= IDLE;
                    end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && pre_found) begin
                        // Hand over without a bubble cycle.
                        grant    <= ONE << pre_pick;
                        grant_id <= pre_pick;
                        last     <= grant_id;
                        hold_cnt <= HW'(1);
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed plus random checks of rr_grant_arbiter against an integer-level
// model of owner, last-served index and hold time.
module tb_rr_grant_arbiter;

    localparam int unsigned N        = 2;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned IDW      = $clog2(N);

    logic           clk;
    logic           rst;
    logic [N-1:0]   request;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    int total;
    int bad;

    // Reference model state
    int m_owner;
    int m_last;
    int m_hold;

    rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .request    (request),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_hold  = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r);
        bit found;
        int nxt;
        found = 0;
        nxt   = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (!found && r[(m_last + k) % N]) begin
                    found = 1;
                    nxt   = (m_last + k) % N;
                end
            end
            if (found) begin
                m_owner = nxt;
                m_hold  = 1;
            end
        end else if (!r[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_hold  = 0;
        end else begin
            for (int k = 1; k < N; k++) begin
                if (!found && r[(m_owner + k) % N]) begin
                    found = 1;
                    nxt   = (m_owner + k) % N;
                end
            end
            if (MAX_HOLD != 0 && m_hold == MAX_HOLD && found) begin
                m_last  = m_owner;
                m_owner = nxt;
                m_hold  = 1;
            end else if (m_hold < MAX_HOLD) begin
                m_hold++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] exp_g;
        exp_g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        chk({tag, ".grant"}, 32'(grant), 32'(exp_g));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        if (m_owner >= 0) chk({tag, ".id"}, 32'(grant_id), 32'(m_owner));
        chk({tag, ".onehot0"}, 32'($onehot0(grant)), 32'(1));
    endtask

    // Drive request at negedge, let one posedge sample it, check just after.
    task automatic step(input logic [N-1:0] r, input string tag);
        @(negedge clk);
        request = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        request = '0;
        @(negedge clk);
        model_reset();
        chk("reset.grant", 32'(grant), 32'(0));
        chk("reset.valid", 32'(grant_valid), 32'(0));
        chk("reset.id", 32'(grant_id), 32'(0));
        rst = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        request = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // T1: single request, then held one more cycle
        do_reset();
        step(2'b01, "t1.first");
        chk("t1.grant01", 32'(grant), 32'(2'b01));
        step(2'b01, "t1.held");
        step(2'b00, "t1.release");

        // T2: drop owner, expect one bubble then requester 1
        do_reset();
        step(2'b11, "t2.a");
        chk("t2.grant01", 32'(grant), 32'(2'b01));
        step(2'b10, "t2.bubble");
        chk("t2.bubble00", 32'(grant), 32'(2'b00));
        step(2'b10, "t2.next");
        chk("t2.grant10", 32'(grant), 32'(2'b10));
        step(2'b00, "t2.end");

        // T3: both held, pre-emption every MAX_HOLD cycles
        do_reset();
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            step(2'b11, "t3");
            chk("t3.rotation", 32'(grant), 32'(((i / MAX_HOLD) % 2 == 0) ? 2'b01 : 2'b10));
        end

        // T4: lone requester is never pre-empted
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(2'b01, "t4");
            chk("t4.steady", 32'(grant), 32'(2'b01));
        end

        // T5: after owner 1 releases, requester 0 wins
        do_reset();
        step(2'b10, "t5.own1");
        step(2'b00, "t5.rel");
        step(2'b11, "t5.both");
        chk("t5.grant01", 32'(grant), 32'(2'b01));

        // T6: asynchronous reset between edges
        do_reset();
        step(2'b11, "t6.a");
        step(2'b11, "t6.b");
        #2;
        rst = 1'b1;
        #1;
        chk("t6.async.grant", 32'(grant), 32'(0));
        chk("t6.async.valid", 32'(grant_valid), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(2'b11, "t6.after");
        chk("t6.grant01", 32'(grant), 32'(2'b01));

        // Random traffic, biased so owners often keep requesting
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            r = N'($urandom_range(0, (1 << N) - 1));
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            step(r, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
